biriscv_fetch_queue: RTL and testbench

BIRISCV_FETCH_QUEUE -- requirements
Module: biriscv_fetch_queue

---
 rtl/biriscv_fetch_queue_if.sv | 36 +++
 rtl/biriscv_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_biriscv_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_fetch_queue_if.sv
// Fetch queue bus: the fetch-packet input side and the issue-lane output side.
// slave  = the queue itself, master = whoever drives packets in and consumes lanes.
interface biriscv_fetch_queue_if #(
    parameter int FETCH_WORDS = 2,
    parameter int ISSUE_WIDTH = 2
);
    logic                        in_valid_i;
    logic [32*FETCH_WORDS-1:0]   in_instr_i;
    logic [31:0]                 in_pc_i;
    logic [FETCH_WORDS-1:0]      in_pred_branch_i;
    logic                        in_fault_fetch_i;
    logic                        in_fault_page_i;
    logic                        in_accept_o;

    logic [ISSUE_WIDTH-1:0]      out_valid_o;
    logic [32*ISSUE_WIDTH-1:0]   out_instr_o;
    logic [32*ISSUE_WIDTH-1:0]   out_pc_o;
    logic [ISSUE_WIDTH-1:0]      out_fault_fetch_o;
    logic [ISSUE_WIDTH-1:0]      out_fault_page_o;
    logic [ISSUE_WIDTH-1:0]      out_pred_branch_o;
    logic [ISSUE_WIDTH-1:0]      out_accept_i;

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, in_pred_branch_i,
               in_fault_fetch_i, in_fault_page_i, out_accept_i,
        output in_accept_o, out_valid_o, out_instr_o, out_pc_o,
               out_fault_fetch_o, out_fault_page_o, out_pred_branch_o
    );

    modport master (
        output in_valid_i, in_instr_i, in_pc_i, in_pred_branch_i,
               in_fault_fetch_i, in_fault_page_i, out_accept_i,
        input  in_accept_o, out_valid_o, out_instr_o, out_pc_o,
               out_fault_fetch_o, out_fault_page_o, out_pred_branch_o
    );
endinterface

// File: rtl/biriscv_fetch_queue.sv
// Fetch queue: trims fetch packets to the useful word range (fetch PC up to the
// first predicted-taken word), stores them in a circular buffer and presents
// the oldest entries on ISSUE_WIDTH in-order lanes.
// Optional statistics (high-water mark, stalled-input cycles) are built when
// the macro BIRISCV_FETCHQ_STATS_EN is defined.
module biriscv_fetch_queue #(
    parameter int FETCH_WORDS = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int DEPTH_W     = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    biriscv_fetch_queue_if.slave fq,
    output logic [DEPTH_W:0]     count_o
`ifdef BIRISCV_FETCHQ_STATS_EN
    ,
    output logic [DEPTH_W:0]     hwm_o,
    output logic [31:0]          full_cycles_o
`endif
);
    localparam int FW_W  = $clog2(FETCH_WORDS);
    localparam int CNT_W = DEPTH_W + 1;

    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Storage is never reset: out_valid_o masks anything stale.
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic        mem_pred  [DEPTH];
    logic        mem_ff    [DEPTH];
    logic        mem_fp    [DEPTH];

    logic [FW_W-1:0]    first_idx;
    logic [FW_W-1:0]    last_idx;
    logic               pred_hit;
    logic               packet_fault;
    logic               push_en;
    logic [CNT_W-1:0]   push_amt;
    logic [CNT_W-1:0]   pop_cnt;
    logic               pop_run;
    logic               wr_en  [FETCH_WORDS];
    logic [DEPTH_W-1:0] wr_idx [FETCH_WORDS];

    logic unused_pc_bits;
    assign unused_pc_bits = ^fq.in_pc_i[1:0];

    assign packet_fault = fq.in_fault_fetch_i | fq.in_fault_page_i;
    assign first_idx    = fq.in_pc_i[FW_W+1:2];

    // Useful word range: fetch PC word up to the first predicted-taken word;
    // a faulting packet only carries its first word.
    always_comb begin
        last_idx = FW_W'(FETCH_WORDS - 1);
        pred_hit = 1'b0;
        for (int j = 0; j < FETCH_WORDS; j++) begin
            if (!pred_hit && (j >= int'(first_idx)) && fq.in_pred_branch_i[j]) begin
                last_idx = FW_W'(j);
                pred_hit = 1'b1;
            end
        end
        if (packet_fault)
            last_idx = first_idx;
    end

    // Room for a whole packet is judged on the registered count only, so a pop
    // in the same cycle never opens the input early.
    assign fq.in_accept_o = rst_ni & ~flush_i &
                            ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WORDS));
    assign push_en  = fq.in_valid_i & fq.in_accept_o;
    assign push_amt = push_en ? (CNT_W'(last_idx) - CNT_W'(first_idx) + CNT_W'(1))
                              : '0;

    // Per-word write enables and slot addresses, packed from the write pointer.
    always_comb begin
        for (int j = 0; j < FETCH_WORDS; j++) begin
            wr_en[j]  = push_en && (j >= int'(first_idx)) && (j <= int'(last_idx));
            wr_idx[j] = wr_ptr_q + DEPTH_W'(j) - DEPTH_W'(first_idx);
        end
    end

    // Pops are the run of leading lanes that are both valid and accepted.
    always_comb begin
        pop_cnt = '0;
        pop_run = 1'b1;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (pop_run && fq.out_valid_o[k] && fq.out_accept_i[k])
                pop_cnt = pop_cnt + CNT_W'(1);
            else
                pop_run = 1'b0;
        end
    end

    // Lane k presents the k-th oldest entry.
    always_comb begin
        fq.out_valid_o       = '0;
        fq.out_instr_o       = '0;
        fq.out_pc_o          = '0;
        fq.out_fault_fetch_o = '0;
        fq.out_fault_page_o  = '0;
        fq.out_pred_branch_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            fq.out_valid_o[k]         = ~flush_i && (count_q > CNT_W'(k));
            fq.out_instr_o[k*32 +: 32] = mem_instr[rd_ptr_q + DEPTH_W'(k)];
            fq.out_pc_o[k*32 +: 32]    = mem_pc[rd_ptr_q + DEPTH_W'(k)];
            fq.out_fault_fetch_o[k]   = mem_ff[rd_ptr_q + DEPTH_W'(k)];
            fq.out_fault_page_o[k]    = mem_fp[rd_ptr_q + DEPTH_W'(k)];
            fq.out_pred_branch_o[k]   = mem_pred[rd_ptr_q + DEPTH_W'(k)];
        end
    end

    // Write the useful words of an accepted packet into consecutive slots.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < FETCH_WORDS; j++) begin
            if (wr_en[j]) begin
                mem_instr[wr_idx[j]] <= fq.in_instr_i[j*32 +: 32];
                mem_pc[wr_idx[j]]    <= {fq.in_pc_i[31:FW_W+2], FW_W'(j), 2'b00};
                mem_pred[wr_idx[j]]  <= fq.in_pred_branch_i[j];
                mem_ff[wr_idx[j]]    <= fq.in_fault_fetch_i;
                mem_fp[wr_idx[j]]    <= fq.in_fault_page_i;
            end
        end
    end

    // Pointers and occupancy; flush wins over any push or pop that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(push_amt);
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(pop_cnt);
            count_q  <= count_q + push_amt - pop_cnt;
        end
    end

    assign count_o = count_q;

`ifdef BIRISCV_FETCHQ_STATS_EN
    logic [CNT_W-1:0] hwm_q;
    logic [31:0]      full_cycles_q;

    // High-water mark and saturating stalled-input counter; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q         <= '0;
            full_cycles_q <= '0;
        end else begin
            if (count_q > hwm_q)
                hwm_q <= count_q;
            if (fq.in_valid_i && !fq.in_accept_o && (full_cycles_q != '1))
                full_cycles_q <= full_cycles_q + 32'd1;
        end
    end

    assign hwm_o         = hwm_q;
    assign full_cycles_o = full_cycles_q;
`endif

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Self-checking bench for biriscv_fetch_queue (FETCH_WORDS=2, ISSUE_WIDTH=2,
// DEPTH=8): directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based reference model.
module tb_biriscv_fetch_queue;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [DW:0] count;
`ifdef BIRISCV_FETCHQ_STATS_EN
    logic [DW:0] hwm;
    logic [31:0] full_cycles;
`endif

    always #5 clk = ~clk;

    biriscv_fetch_queue_if #(.FETCH_WORDS(FW), .ISSUE_WIDTH(IW)) bus ();

    biriscv_fetch_queue #(.FETCH_WORDS(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .DEPTH_W(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .fq      (bus),
        .count_o (count)
`ifdef BIRISCV_FETCHQ_STATS_EN
        ,
        .hwm_o         (hwm),
        .full_cycles_o (full_cycles)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        ff;
        logic        fp;
    } ent_t;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] instr,
                         input logic [1:0] pred, input logic ff, input logic fp,
                         input logic [1:0] acc, input logic fl);
        bus.in_valid_i       = v;
        bus.in_pc_i          = pc;
        bus.in_instr_i       = instr;
        bus.in_pred_branch_i = pred;
        bus.in_fault_fetch_i = ff;
        bus.in_fault_page_i  = fp;
        bus.out_accept_i     = acc;
        flush                = fl;
        #1;
    endtask

    task automatic idle(input logic [1:0] acc);
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, acc, 1'b0);
    endtask

    // Expected outputs straight from the model contents.
    task automatic compare_model();
        int   n;
        logic ev;
        n = model_q.size();
        chk("count", 64'(count), 64'(n));
        chk("in_accept", 64'(bus.in_accept_o), 64'(rst_n && !flush && (DEPTH - n >= FW)));
        for (int k = 0; k < IW; k++) begin
            ev = (n > k) && !flush;
            chk($sformatf("lane%0d_valid", k), 64'(bus.out_valid_o[k]), 64'(ev));
            if (ev) begin
                chk($sformatf("lane%0d_instr", k), 64'(bus.out_instr_o[k*32 +: 32]), 64'(model_q[k].instr));
                chk($sformatf("lane%0d_pc", k), 64'(bus.out_pc_o[k*32 +: 32]), 64'(model_q[k].pc));
                chk($sformatf("lane%0d_pred", k), 64'(bus.out_pred_branch_o[k]), 64'(model_q[k].pred));
                chk($sformatf("lane%0d_ffetch", k), 64'(bus.out_fault_fetch_o[k]), 64'(model_q[k].ff));
                chk($sformatf("lane%0d_fpage", k), 64'(bus.out_fault_page_o[k]), 64'(model_q[k].fp));
            end
        end
    endtask

    // Model update at a clock edge, using the inputs held across it.
    task automatic model_edge();
        int   pops;
        int   first;
        logic room;
        ent_t e;
        if (!rst_n || flush) begin
            model_q.delete();
            return;
        end
        room = (DEPTH - model_q.size()) >= FW;
        pops = 0;
        while (pops < IW && pops < model_q.size() && bus.out_accept_i[pops]) pops++;
        repeat (pops) model_q.delete(0);
        if (bus.in_valid_i && room) begin
            first = (bus.in_pc_i >> 2) % FW;
            for (int j = first; j < FW; j++) begin
                e.instr = bus.in_instr_i[j*32 +: 32];
                e.pc    = (bus.in_pc_i & ~32'(FW*4 - 1)) + 32'(j*4);
                e.pred  = bus.in_pred_branch_i[j];
                e.ff    = bus.in_fault_fetch_i;
                e.fp    = bus.in_fault_page_i;
                model_q.push_back(e);
                if (bus.in_fault_fetch_i || bus.in_fault_page_i || bus.in_pred_branch_i[j]) break;
            end
        end
    endtask

    task automatic tick();
        compare_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_cycle(input int acc_bias);
        logic [1:0] acc;
        acc = ($urandom_range(0, 99) < acc_bias) ? 2'($urandom_range(0, 3)) : 2'b00;
        drive($urandom_range(0, 3) != 0,
              $urandom & 32'hFFFF_FFFC,
              {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0,
              acc,
              $urandom_range(0, 31) == 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2'b00);
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("rst_accept", 64'(bus.in_accept_o), 64'h0);

        // Aligned two-word packet
        rst_n = 1'b1;
        drive(1'b1, 32'h1000, {32'hBBBB_0001, 32'hAAAA_0000}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("accept_after_reset", 64'(bus.in_accept_o), 64'h1);
        tick();
        idle(2'b00);
        chk("ab_count", 64'(count), 64'h2);
        chk("ab_valid", 64'(bus.out_valid_o), 64'h3);
        chk("ab_l0_instr", 64'(bus.out_instr_o[31:0]), 64'hAAAA_0000);
        chk("ab_l0_pc", 64'(bus.out_pc_o[31:0]), 64'h1000);
        chk("ab_l1_instr", 64'(bus.out_instr_o[63:32]), 64'hBBBB_0001);
        chk("ab_l1_pc", 64'(bus.out_pc_o[63:32]), 64'h1004);
        tick();
        idle(2'b11);
        tick();

        // Unaligned start: only word 1
        drive(1'b1, 32'h1004, {32'hDDDD_0003, 32'hCCCC_0002}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        idle(2'b00);
        chk("unal_count", 64'(count), 64'h1);
        chk("unal_instr", 64'(bus.out_instr_o[31:0]), 64'hDDDD_0003);
        chk("unal_pc", 64'(bus.out_pc_o[31:0]), 64'h1004);
        tick();

        // Predicted-taken word 0 truncates the packet; pop the old entry at once
        drive(1'b1, 32'h2000, {32'hFFFF_0005, 32'hEEEE_0004}, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        idle(2'b00);
        chk("pred_count", 64'(count), 64'h1);
        chk("pred_instr", 64'(bus.out_instr_o[31:0]), 64'hEEEE_0004);
        chk("pred_pc", 64'(bus.out_pc_o[31:0]), 64'h2000);
        chk("pred_flag", 64'(bus.out_pred_branch_o[0]), 64'h1);
        tick();
        idle(2'b01);
        tick();

        // Faulting packet: only the first word, with flags
        drive(1'b1, 32'h3000, {32'h1111_0007, 32'h9999_0006}, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
        tick();
        idle(2'b00);
        chk("fault_count", 64'(count), 64'h1);
        chk("fault_instr", 64'(bus.out_instr_o[31:0]), 64'h9999_0006);
        chk("fault_ff", 64'(bus.out_fault_fetch_o[0]), 64'h1);
        chk("fault_fp", 64'(bus.out_fault_page_o[0]), 64'h0);
        tick();
        idle(2'b01);
        tick();

        // Fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h4000 + 32'(8*i), {32'(2*i+1), 32'(2*i)}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            tick();
        end
        drive(1'b1, 32'h5000, 64'h0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
        chk("full8_count", 64'(count), 64'h8);
        chk("full8_accept", 64'(bus.in_accept_o), 64'h0);
        tick();
        drive(1'b1, 32'h5000, 64'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("full7_count", 64'(count), 64'h7);
        chk("full7_accept", 64'(bus.in_accept_o), 64'h0);
        tick();
        drive(1'b1, 32'h5000, 64'h0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        idle(2'b00);
        chk("c6_count", 64'(count), 64'h6);
        chk("c6_accept", 64'(bus.in_accept_o), 64'h1);
        tick();

        // Lane accept rules
        idle(2'b11); tick();
        idle(2'b01); tick();
        idle(2'b10);
        chk("c3_count", 64'(count), 64'h3);
        tick();
        idle(2'b00);
        chk("acc10_nopop", 64'(count), 64'h3);
        tick();
        idle(2'b11); tick();
        idle(2'b00);
        chk("acc11_count", 64'(count), 64'h1);
        tick();
        drive(1'b1, 32'h6000, {32'h6, 32'h5}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 32'h6008, {32'h8, 32'h7}, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
        tick();
        idle(2'b00);
        chk("pushpop_count", 64'(count), 64'h3);
        tick();

        // Flush with count 5 and an incoming packet
        drive(1'b1, 32'h6010, {32'hA, 32'h9}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 32'h6018, {32'hC, 32'hB}, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1);
        chk("flush_pre_count", 64'(count), 64'h5);
        chk("flush_valid", 64'(bus.out_valid_o), 64'h0);
        chk("flush_accept", 64'(bus.in_accept_o), 64'h0);
        tick();
        idle(2'b00);
        chk("flush_count", 64'(count), 64'h0);
        tick();

        // Random traffic, alternately draining and filling
        for (int i = 0; i < 1500; i++) rand_cycle((i / 100) % 2 == 0 ? 80 : 20);
        for (int i = 0; i < 20; i++) rand_cycle(0);

        // Reset in mid-stream
        drive(1'b1, 32'h7000, 64'h0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("midrst_count", 64'(count), 64'h0);
        chk("midrst_accept", 64'(bus.in_accept_o), 64'h0);
        model_q.delete();
        @(negedge clk);
        idle(2'b00);
        rst_n = 1'b1;

`ifdef BIRISCV_FETCHQ_STATS_EN
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8000 + 32'(8*i), {32'(i+100), 32'(i)}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h9000, 64'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
        chk("stats_hwm", 64'(hwm), 64'h8);
        chk("stats_full", 64'(full_cycles), 64'h3);
        tick();
        idle(2'b00);
        chk("stats_hwm_flush", 64'(hwm), 64'h8);
        chk("stats_full_flush", 64'(full_cycles), 64'h3);
        tick();
`endif

        for (int i = 0; i < 500; i++) rand_cycle(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
